parking_occupancy: RTL and testbench
====================================

PARKING_OCCUPANCY -- requirements
Module: parking_occupancy

Interface
REQ-001 Parameter CAPACITY, default 16: number of parking spaces, legal range 1..255.
REQ-002 Parameter CNT_W, default 8: width of the count output; SHALL be at least clog2(CAPACITY+1).
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 Port in, input, 2 bits: per-entry car-entering pulse, one cycle per car, from the two-entry detector.
REQ-006 Port out, input, 2 bits: per-entry car-leaving pulse, one cycle per car.
REQ-007 Port sensor_err, input, 1 bit: detector error, level or pulse.
REQ-008 Port clr_fault, input, 1 bit: single-cycle request to leave FAULT.
REQ-009 Port count, output, CNT_W bits: current occupancy, registered.
REQ-010 Port full, output, 1 bit: high when count equals CAPACITY, registered.
REQ-011 Port empty, output, 1 bit: high when count equals 0, registered.
REQ-012 Port overflow, output, 1 bit: one-cycle pulse when entries would exceed CAPACITY.
REQ-013 Port underflow, output, 1 bit: one-cycle pulse when exits would take count below 0.
REQ-014 Port fault, output, 1 bit: high while the FSM is in FAULT.

Function
REQ-015 Per cycle: n_in = popcount(in), 0..2; n_out = popcount(out), 0..2; delta = n_in - n_out, signed, range -2..+2.
REQ-016 In non-FAULT states, next count = clamp(count + delta, 0, CAPACITY), registered; count, full and empty SHALL reflect events one cycle after the input pulses.
REQ-017 If count + delta > CAPACITY: count SHALL saturate at CAPACITY and overflow SHALL pulse for exactly one cycle, in the same cycle the count updates.
REQ-018 If count + delta < 0: count SHALL saturate at 0 and underflow SHALL pulse for exactly one cycle.
REQ-019 Simultaneous entries and exits SHALL be netted before the clamp. Example: count=CAPACITY with in=2'b11 and out=2'b01 gives count=CAPACITY and overflow=1.
REQ-020 FSM states: EMPTY (count 0), PARTIAL (0 < count < CAPACITY), FULL (count = CAPACITY), FAULT. The state SHALL be derived from the next count whenever the FSM is not entering or in FAULT.
REQ-021 Any state SHALL go to FAULT on sensor_err=1. sensor_err SHALL take priority over in/out in the same cycle; that cycle's events are discarded.
REQ-022 In FAULT: count SHALL hold, all in/out pulses SHALL be ignored, overflow=0, underflow=0, fault=1.
REQ-023 FAULT SHALL exit only on a cycle with clr_fault=1 and sensor_err=0, going to EMPTY, PARTIAL or FULL according to the held count; in/out on that exit cycle SHALL be ignored.
REQ-024 clr_fault outside FAULT SHALL have no effect.
REQ-025 full SHALL equal (state==FULL); empty SHALL equal (state==EMPTY). In FAULT, full and empty SHALL both be 0.

Reset
REQ-026 While rst=0: count=0, state=EMPTY, empty=1, full=0, overflow=0, underflow=0, fault=0, asynchronously.
REQ-027 Reset mid-operation, including in FAULT, SHALL discard all state; the first edge after rst deasserts SHALL process inputs normally.

Configuration
REQ-028 Macro PARKING_OCC_STATS_EN.
- Defined: SHALL add 16-bit outputs total_in and total_out, counting accepted entry and exit events (after clamping, excluding FAULT cycles), wrapping modulo 2^16, reset to 0.
- Undefined: these ports and their counters SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-029 Reset, then in=2'b01 for 3 single-cycle pulses -> count=3, empty=0 one cycle after the last pulse.
REQ-030 CAPACITY=16, count=15, in=2'b11 for one cycle -> count=16, full=1, overflow=1 for exactly one cycle.
REQ-031 count=1, out=2'b11 -> count=0, empty=1, underflow=1 for one cycle.
REQ-032 count=5, in=2'b11 and out=2'b11 in the same cycle -> count=5, no flag pulses.
REQ-033 count=7, sensor_err=1 with in=2'b01 -> fault=1, count=7; further in/out ignored; clr_fault=1 -> PARTIAL, fault=0, count=7.
REQ-034 rst=0 asserted mid-FAULT with count=9 -> count=0, fault=0, empty=1 immediately; with the macro defined, total_in=0 and total_out=0.

Source files
------------

// File: rtl/parking_occupancy.sv
`default_nettype none
// ============================================================================
// Module      : parking_occupancy
// Description : Two-entry car park occupancy counter. It nets per-cycle
//               entry and exit pulses, clamps the count to the range
//               0..CAPACITY, and flags overflow and underflow. A FAULT state
//               freezes the count while the detector reports an error.
// Ports       : clk, rst (async active-low)
//               in[1:0], out[1:0]  - per-entry car enter/leave pulses
//               sensor_err         - detector error (level or pulse)
//               clr_fault          - request to leave FAULT
//               count, full, empty - registered occupancy state
//               overflow/underflow - one-cycle clamp pulses
//               fault              - high while in FAULT
//               total_in/total_out - accepted event totals (optional)
// Options     : `define PARKING_OCC_STATS_EN adds total_in and total_out
// Revision    : 1.0 - initial release
// ============================================================================
module parking_occupancy #(
    parameter int CAPACITY = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       in,
    input  logic [1:0]       out,
    input  logic             sensor_err,
    input  logic             clr_fault,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow,
`ifdef PARKING_OCC_STATS_EN
    output logic [15:0]      total_in,
    output logic [15:0]      total_out,
`endif
    output logic             fault
);

    // Two guard bits: one for the +2 carry, one for the sign.
    localparam int W = CNT_W + 2;

    localparam logic signed [W-1:0] c_cap_w   = W'(CAPACITY);
    localparam logic [CNT_W-1:0]    c_cap_cnt = CNT_W'(CAPACITY);

    localparam logic [1:0] S_EMPTY   = 2'd0;
    localparam logic [1:0] S_PARTIAL = 2'd1;
    localparam logic [1:0] S_FULL    = 2'd2;
    localparam logic [1:0] S_FAULT   = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic [1:0]              w_n_in;
    logic [1:0]              w_n_out;
    logic signed [W-1:0]     w_delta;
    logic signed [W-1:0]     w_sum;
    logic                    w_ovf;
    logic                    w_unf;
    logic [CNT_W-1:0]        w_next_count;
    logic                    w_normal;

    assign w_n_in  = {1'b0, in[0]}  + {1'b0, in[1]};
    assign w_n_out = {1'b0, out[0]} + {1'b0, out[1]};

    // Entries and exits are netted before clamping.
    assign w_delta = $signed({{(W-2){1'b0}}, w_n_in}) - $signed({{(W-2){1'b0}}, w_n_out});
    assign w_sum   = $signed({2'b00, r_count}) + w_delta;

    assign w_ovf = (w_sum > c_cap_w);
    assign w_unf = w_sum[W-1];

    // Events only count when not faulted and not entering FAULT this cycle.
    assign w_normal = !sensor_err && (r_state != S_FAULT);

    always_comb begin
        w_next_count = w_sum[CNT_W-1:0];
        if (w_ovf) begin
            w_next_count = c_cap_cnt;
        end else if (w_unf) begin
            w_next_count = '0;
        end
    end

    function automatic logic [1:0] state_of(input logic [CNT_W-1:0] c);
        if (c == '0) begin
            return S_EMPTY;
        end else if (c == c_cap_cnt) begin
            return S_FULL;
        end else begin
            return S_PARTIAL;
        end
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_EMPTY;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            if (sensor_err) begin
                // Error wins over any same-cycle events; they are dropped.
                r_state <= S_FAULT;
            end else if (r_state == S_FAULT) begin
                if (clr_fault) begin
                    r_state <= state_of(r_count);
                end
            end else begin
                r_count     <= w_next_count;
                r_state     <= state_of(w_next_count);
                r_overflow  <= w_ovf;
                r_underflow <= w_unf;
            end
        end
    end

`ifdef PARKING_OCC_STATS_EN
    logic [15:0] r_total_in;
    logic [15:0] r_total_out;
    logic [1:0]  w_room;
    logic [1:0]  w_acc_in;
    logic [1:0]  w_acc_out;

    // On overflow the free room is at most 1, on underflow the count is at
    // most 1, so 2-bit slices hold the whole value in those cases.
    assign w_room = c_cap_cnt[1:0] - r_count[1:0];

    always_comb begin
        w_acc_in  = w_n_in;
        w_acc_out = w_n_out;
        if (w_ovf) begin
            // All exits accepted; entries only fill the remaining room.
            w_acc_in = w_n_out + w_room;
        end else if (w_unf) begin
            // All entries accepted; exits only drain what was present.
            w_acc_out = w_n_in + r_count[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_total_in  <= '0;
            r_total_out <= '0;
        end else if (w_normal) begin
            r_total_in  <= r_total_in  + {14'd0, w_acc_in};
            r_total_out <= r_total_out + {14'd0, w_acc_out};
        end
    end

    assign total_in  = r_total_in;
    assign total_out = r_total_out;
`else
    logic w_unused_normal;
    assign w_unused_normal = w_normal;
`endif

    assign count     = r_count;
    assign full      = (r_state == S_FULL);
    assign empty     = (r_state == S_EMPTY);
    assign fault     = (r_state == S_FAULT);
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_parking_occupancy.sv
`default_nettype none
// ============================================================================
// Module      : tb_parking_occupancy
// Description : Self-checking bench for parking_occupancy (CAPACITY=16).
//               Table of cycle vectors plus hand-written reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_occupancy;

    localparam int CAPACITY = 16;
    localparam int CNT_W    = 8;

    logic             clk;
    logic             rst;
    logic [1:0]       in;
    logic [1:0]       out;
    logic             sensor_err;
    logic             clr_fault;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;
    logic             fault;
`ifdef PARKING_OCC_STATS_EN
    logic [15:0]      total_in;
    logic [15:0]      total_out;
`endif

    int total;
    int bad;

    parking_occupancy #(
        .CAPACITY (CAPACITY),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in),
        .out        (out),
        .sensor_err (sensor_err),
        .clr_fault  (clr_fault),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .underflow  (underflow),
`ifdef PARKING_OCC_STATS_EN
        .total_in   (total_in),
        .total_out  (total_out),
`endif
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] v_in;
        logic [1:0] v_out;
        logic       v_err;
        logic       v_clr;
        int         e_count;
        logic       e_full;
        logic       e_empty;
        logic       e_ovf;
        logic       e_unf;
        logic       e_fault;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] i, input logic [1:0] o, input logic e,
                       input logic c, input int ec, input logic ef, input logic ee,
                       input logic eo, input logic eu, input logic ft);
        vec_t v;
        v.v_in = i; v.v_out = o; v.v_err = e; v.v_clr = c;
        v.e_count = ec; v.e_full = ef; v.e_empty = ee;
        v.e_ovf = eo; v.e_unf = eu; v.e_fault = ft;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int ec, input logic ef, input logic ee,
                           input logic eo, input logic eu, input logic ft);
        chk({tag, ".count"},     int'(count),     ec);
        chk({tag, ".full"},      int'(full),      int'(ef));
        chk({tag, ".empty"},     int'(empty),     int'(ee));
        chk({tag, ".overflow"},  int'(overflow),  int'(eo));
        chk({tag, ".underflow"}, int'(underflow), int'(eu));
        chk({tag, ".fault"},     int'(fault),     int'(ft));
    endtask

    // Inputs are applied just after a rising edge and sampled 1 time unit
    // after the next one.
    task automatic cycle(input logic [1:0] i, input logic [1:0] o, input logic e,
                         input logic c);
        in = i; out = o; sensor_err = e; clr_fault = c;
        @(posedge clk);
        #1;
        in = 2'b00; out = 2'b00; sensor_err = 1'b0; clr_fault = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0; in = 2'b00; out = 2'b00; sensor_err = 1'b0; clr_fault = 1'b0;

        // Vector table: {in, out, err, clr} -> {count, full, empty, ovf, unf, fault}
        add(2'b01, 2'b00, 0, 0,  1, 0, 0, 0, 0, 0);
        add(2'b01, 2'b00, 0, 0,  2, 0, 0, 0, 0, 0);
        add(2'b01, 2'b00, 0, 0,  3, 0, 0, 0, 0, 0);
        add(2'b11, 2'b00, 0, 0,  5, 0, 0, 0, 0, 0);
        add(2'b11, 2'b11, 0, 0,  5, 0, 0, 0, 0, 0);
        add(2'b10, 2'b00, 0, 0,  6, 0, 0, 0, 0, 0);
        add(2'b01, 2'b00, 0, 0,  7, 0, 0, 0, 0, 0);
        add(2'b01, 2'b00, 1, 0,  7, 0, 0, 0, 0, 1);   // error beats entry
        add(2'b11, 2'b00, 0, 0,  7, 0, 0, 0, 0, 1);
        add(2'b00, 2'b11, 0, 0,  7, 0, 0, 0, 0, 1);
        add(2'b00, 2'b00, 1, 1,  7, 0, 0, 0, 0, 1);   // clr blocked by err
        add(2'b11, 2'b00, 0, 1,  7, 0, 0, 0, 0, 0);   // exit, entries ignored
        add(2'b00, 2'b11, 0, 0,  5, 0, 0, 0, 0, 0);
        add(2'b00, 2'b11, 0, 0,  3, 0, 0, 0, 0, 0);
        add(2'b00, 2'b10, 0, 0,  2, 0, 0, 0, 0, 0);
        add(2'b00, 2'b01, 0, 0,  1, 0, 0, 0, 0, 0);
        add(2'b00, 2'b11, 0, 0,  0, 0, 1, 0, 1, 0);   // underflow 1-2
        add(2'b00, 2'b00, 0, 0,  0, 0, 1, 0, 0, 0);
        add(2'b00, 2'b01, 0, 0,  0, 0, 1, 0, 1, 0);
        add(2'b01, 2'b01, 0, 0,  0, 0, 1, 0, 0, 0);
        add(2'b01, 2'b00, 0, 1,  1, 0, 0, 0, 0, 0);   // clr outside FAULT
        for (int k = 0; k < 7; k++) begin
            add(2'b11, 2'b00, 0, 0, 3 + 2 * k, 0, 0, 0, 0, 0);
        end
        add(2'b11, 2'b00, 0, 0, 16, 1, 0, 1, 0, 0);   // 15+2 saturates
        add(2'b00, 2'b00, 0, 0, 16, 1, 0, 0, 0, 0);
        add(2'b11, 2'b01, 0, 0, 16, 1, 0, 1, 0, 0);   // netted then clamped
        add(2'b01, 2'b01, 0, 0, 16, 1, 0, 0, 0, 0);
        add(2'b00, 2'b01, 0, 0, 15, 0, 0, 0, 0, 0);
        add(2'b01, 2'b00, 0, 0, 16, 1, 0, 0, 0, 0);
        add(2'b00, 2'b00, 1, 0, 16, 0, 0, 0, 0, 1);   // FULL -> FAULT
        add(2'b00, 2'b00, 1, 1, 16, 0, 0, 0, 0, 1);
        add(2'b00, 2'b00, 0, 1, 16, 1, 0, 0, 0, 0);   // back to FULL

        #12;
        chk_all("reset", 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_reset_idle", 0, 0, 1, 0, 0, 0);

        foreach (vecs[n]) begin
            cycle(vecs[n].v_in, vecs[n].v_out, vecs[n].v_err, vecs[n].v_clr);
            chk_all($sformatf("vec%0d", n), vecs[n].e_count, vecs[n].e_full,
                    vecs[n].e_empty, vecs[n].e_ovf, vecs[n].e_unf, vecs[n].e_fault);
        end

        // Reset asserted in the middle of FAULT with count 9.
        for (int k = 0; k < 4; k++) cycle(2'b11, 2'b00, 0, 0);   // 16 stays 16 (ovf)
        for (int k = 0; k < 4; k++) cycle(2'b00, 2'b11, 0, 0);   // 8
        cycle(2'b01, 2'b00, 0, 0);                               // 9
        chk("seq.count9", int'(count), 9);
        cycle(2'b00, 2'b00, 1, 0);
        chk("seq.fault9", int'(fault), 1);
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_reset", 0, 0, 1, 0, 0, 0);
`ifdef PARKING_OCC_STATS_EN
        chk("async_reset.total_in",  int'(total_in),  0);
        chk("async_reset.total_out", int'(total_out), 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        cycle(2'b01, 2'b00, 0, 0);
        chk_all("first_edge_after_reset", 1, 0, 0, 0, 0, 0);

        // Overflow pulse is exactly one cycle wide even with repeated entries.
        for (int k = 0; k < 7; k++) cycle(2'b11, 2'b00, 0, 0);   // 15
        cycle(2'b11, 2'b00, 0, 0);
        chk_all("ovf_pulse", 16, 1, 0, 1, 0, 0);
        cycle(2'b00, 2'b00, 0, 0);
        chk("ovf_cleared", int'(overflow), 0);

        // No flags while faulted, even when events would overflow.
        cycle(2'b00, 2'b00, 1, 0);
        cycle(2'b11, 2'b00, 0, 0);
        chk_all("fault_no_ovf", 16, 0, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, expected done before 50000");
        $fatal(1);
    end

endmodule
`default_nettype wire
